// File: rtl/shift_scheduler.sv
// Two-requester round-robin front end for an iterative shift engine.
// Accepts one job at a time, shifts one bit per clock, and returns the result tagged by owner.
module shift_scheduler #(
   parameter int WIDTH = 8,
   parameter int NUMW  = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Req0,
   input  logic [WIDTH-1:0] Din0,
   input  logic [1:0]       Mode0,
   input  logic             Drc0,
   input  logic [NUMW-1:0]  Num0,
   output logic             Ack0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] Din1,
   input  logic [1:0]       Mode1,
   input  logic             Drc1,
   input  logic [NUMW-1:0]  Num1,
   output logic             Ack1,
   output logic [WIDTH-1:0] Dout,
   output logic             Done,
   output logic             Owner,
   output logic             Busy
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] work, work_next, step_val, dout_next;
   logic [NUMW-1:0]  cnt, cnt_next;
   logic [2:0]       cmd, cmd_next;
   logic             cur, cur_next, last, last_next;
   logic             ack0_next, ack1_next, done_next, owner_next, busy_next;
   logic             grant;

   // One step of the latched command; cmd is {direction, mode}.
   always_comb begin
      step_val = work;
      case (cmd)
         3'b000, 3'b001: step_val = {work[WIDTH-2:0], 1'b0};
         3'b010:         step_val = {work[WIDTH-2:0], work[WIDTH-1]};
         3'b011:         step_val = {work[WIDTH-2:0], ~work[WIDTH-1]};
         3'b100:         step_val = {1'b0, work[WIDTH-1:1]};
         3'b101:         step_val = {work[WIDTH-1], work[WIDTH-1:1]};
         3'b110:         step_val = {work[0], work[WIDTH-1:1]};
         default:        step_val = {~work[0], work[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_next = state;
      work_next  = work;
      cnt_next   = cnt;
      cmd_next   = cmd;
      cur_next   = cur;
      last_next  = last;
      ack0_next  = 1'b0;
      ack1_next  = 1'b0;
      done_next  = 1'b0;
      dout_next  = Dout;
      owner_next = Owner;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (Req0 || Req1) begin
               // On a tie the requester that did not win last time is served.
               grant      = (Req0 && Req1) ? ~last : Req1;
               work_next  = grant ? Din1 : Din0;
               cnt_next   = grant ? Num1 : Num0;
               cmd_next   = grant ? {Drc1, Mode1} : {Drc0, Mode0};
               cur_next   = grant;
               last_next  = grant;
               ack0_next  = ~grant;
               ack1_next  = grant;
               state_next = SHIFT;
            end
         end
         default: begin
            if (cnt != '0) begin
               work_next = step_val;
               cnt_next  = cnt - 1'b1;
            end else begin
               dout_next  = work;
               owner_next = cur;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
      busy_next = (state_next == SHIFT);
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= '0;
         cmd   <= '0;
         cur   <= 1'b0;
         last  <= 1'b1;
         Ack0  <= 1'b0;
         Ack1  <= 1'b0;
         Done  <= 1'b0;
         Dout  <= '0;
         Owner <= 1'b0;
         Busy  <= 1'b0;
      end else begin
         state <= state_next;
         work  <= work_next;
         cnt   <= cnt_next;
         cmd   <= cmd_next;
         cur   <= cur_next;
         last  <= last_next;
         Ack0  <= ack0_next;
         Ack1  <= ack1_next;
         Done  <= done_next;
         Dout  <= dout_next;
         Owner <= owner_next;
         Busy  <= busy_next;
      end
   end

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler: expected results are queued when a job is
// requested and compared when Done pulses.
module tb_shift_scheduler;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Req0, Req1;
   logic [7:0] Din0, Din1;
   logic [1:0] Mode0, Mode1;
   logic       Drc0, Drc1;
   logic [3:0] Num0, Num1;
   logic       Ack0, Ack1, Done, Owner, Busy;
   logic [7:0] Dout;

   typedef struct {
      logic [7:0] dout;
      logic       owner;
      int         num;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ackCyc[2];

   shift_scheduler #(.WIDTH(8), .NUMW(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .Req0(Req0), .Din0(Din0), .Mode0(Mode0), .Drc0(Drc0), .Num0(Num0), .Ack0(Ack0),
      .Req1(Req1), .Din1(Din1), .Mode1(Mode1), .Drc1(Drc1), .Num1(Num1), .Ack1(Ack1),
      .Dout(Dout), .Done(Done), .Owner(Owner), .Busy(Busy)
   );

   // Free-running clock and edge counter used for latency measurement.
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic who, input logic [7:0] din, input logic drc,
                                input logic [1:0] mode, input logic [3:0] num,
                                input logic [7:0] expDout);
      exp_t e;
      if (who) begin
         Req1 = 1'b1; Din1 = din; Drc1 = drc; Mode1 = mode; Num1 = num;
      end else begin
         Req0 = 1'b1; Din0 = din; Drc0 = drc; Mode0 = mode; Num0 = num;
      end
      e.dout  = expDout;
      e.owner = who;
      e.num   = int'(num);
      sb.push_back(e);
   endtask

   task automatic waitAck(input logic who);
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if ((who ? Ack1 : Ack0) === 1'b1) begin
            seen = 1;
            break;
         end
      end
      checkValue(who ? "ack1_seen" : "ack0_seen", 32'(seen), 32'd1);
      checkValue(who ? "ack0_idle" : "ack1_idle", 32'(who ? Ack0 : Ack1), 32'd0);
      checkValue("busy_at_ack", 32'(Busy), 32'd1);
      ackCyc[who] = cyc;
      if (who) Req1 = 1'b0;
      else     Req0 = 1'b0;
   endtask

   task automatic checkOutput();
      bit   seen = 0;
      exp_t e;
      for (int i = 0; i < 40; i++) begin
         if (Done === 1'b1) begin
            seen = 1;
            break;
         end
         @(negedge Clk);
      end
      checkValue("done_seen", 32'(seen), 32'd1);
      if (sb.size() == 0) begin
         checkValue("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         checkValue("dout", 32'(Dout), 32'(e.dout));
         checkValue("owner", 32'(Owner), 32'(e.owner));
         checkValue("busy_at_done", 32'(Busy), 32'd0);
         checkValue("latency", 32'(cyc - ackCyc[e.owner]), 32'(e.num + 1));
      end
   endtask

   initial begin
      bit sawDone;
      Rst = 1'b1;
      Req0 = 0; Din0 = '0; Mode0 = '0; Drc0 = 0; Num0 = '0;
      Req1 = 0; Din1 = '0; Mode1 = '0; Drc1 = 0; Num1 = '0;
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      checkValue("rst_ack0", 32'(Ack0), 32'd0);
      checkValue("rst_ack1", 32'(Ack1), 32'd0);
      checkValue("rst_done", 32'(Done), 32'd0);
      checkValue("rst_busy", 32'(Busy), 32'd0);
      checkValue("rst_dout", 32'(Dout), 32'd0);
      checkValue("rst_owner", 32'(Owner), 32'd0);

      // Arithmetic right of 1001_0110 by 3.
      applyStimulus(0, 8'b1001_0110, 1'b1, 2'b01, 4'd3, 8'b1111_0010);
      waitAck(0);
      @(negedge Clk);
      checkValue("ack0_one_cycle", 32'(Ack0), 32'd0);
      checkValue("busy_mid", 32'(Busy), 32'd1);
      checkOutput();
      @(negedge Clk);
      checkValue("done_one_cycle", 32'(Done), 32'd0);

      // Tie: last was 0, so requester 1 would win; reset first to make requester 0 win.
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      applyStimulus(0, 8'h81, 1'b0, 2'b10, 4'd1, 8'h03);
      applyStimulus(1, 8'h0F, 1'b0, 2'b00, 4'd4, 8'hF0);
      waitAck(0);
      checkOutput();
      waitAck(1);
      checkOutput();

      applyStimulus(0, 8'hA5, 1'b0, 2'b10, 4'd0, 8'hA5);
      waitAck(0);
      checkOutput();

      applyStimulus(1, 8'h00, 1'b1, 2'b11, 4'd8, 8'hFF);
      waitAck(1);
      checkOutput();
      applyStimulus(0, 8'h00, 1'b1, 2'b11, 4'd15, 8'h01);
      waitAck(0);
      checkOutput();

      applyStimulus(0, 8'hFF, 1'b0, 2'b00, 4'd12, 8'h00);
      waitAck(0);
      checkOutput();
      applyStimulus(0, 8'h01, 1'b1, 2'b10, 4'd9, 8'h80);
      waitAck(0);
      checkOutput();
      applyStimulus(1, 8'h80, 1'b1, 2'b01, 4'd15, 8'hFF);
      waitAck(1);
      checkOutput();

      // Abort a Num=10 job with reset at its third shift edge.
      applyStimulus(0, 8'h5A, 1'b0, 2'b00, 4'd10, 8'h00);
      waitAck(0);
      void'(sb.pop_back());
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      checkValue("abort_busy", 32'(Busy), 32'd0);
      checkValue("abort_dout", 32'(Dout), 32'd0);
      checkValue("abort_owner", 32'(Owner), 32'd0);
      sawDone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge Clk);
         if (Done === 1'b1) sawDone = 1;
      end
      checkValue("abort_no_done", 32'(sawDone), 32'd0);

      applyStimulus(1, 8'h3C, 1'b1, 2'b10, 4'd2, 8'h0F);
      waitAck(1);
      checkOutput();

      // last is now 1, so requester 0 wins this tie.
      applyStimulus(0, 8'h01, 1'b0, 2'b11, 4'd2, 8'h07);
      applyStimulus(1, 8'h80, 1'b1, 2'b00, 4'd1, 8'h40);
      waitAck(0);
      checkOutput();
      waitAck(1);
      checkOutput();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

endmodule
